decode_field_stage: RTL and testbench
=====================================

Name: decode_field_stage

Overview:
- Pipeline stage between instruction fetch and the immediate/displacement sign extenders.
- Accepts fetched instructions with their PC over a valid/ready handshake.
- Splits each instruction into opcode, register and raw immediate fields, then presents them registered to downstream.
- Provides a 2-entry skid buffer so the fetch-side ready is fully registered, plus a synchronous flush for branch redirects.

Parameters:
- INST_W, 32, instruction width (fixed field map below assumes 32).
- PC_W, 32, program counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discard all held and incoming instructions this cycle.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept; driven from a register.
- in_inst  in  INST_W  instruction word.
- in_pc  in  PC_W  instruction address.
- out_valid  out  1  decoded fields valid.
- out_ready  in  1  downstream accepts.
- out_pc  out  PC_W  PC of the presented instruction.
- out_opcode  out  5  inst[31:27].
- out_fmt  out  2  inst[31:30]: 00 reg, 01 imm18, 10 md22, 11 branch (md22).
- out_ra  out  5  inst[26:22].
- out_rb  out  5  inst[21:17].
- out_rc  out  5  inst[16:12].
- out_imm18  out  18  inst[17:0], raw, to the 18-bit sign extender.
- out_md22  out  22  inst[21:0], raw, to the 22-bit sign extender.
- out_uses_imm  out  1  out_fmt==01.
- out_uses_md  out  1  out_fmt[1]==1.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, skid_valid=0, in_ready=1.
  - All data outputs and skid contents = 0.
- Storage:
  - Main register M drives all out_* signals.
  - Skid register S holds {inst, pc}.
  - Fields are extracted combinationally from the stored instruction word and are therefore stable whenever out_valid=1.
- Handshake:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - out_* must hold unchanged while out_valid=1 and out_ready=0.
- State transitions, evaluated at each edge when flush=0, keyed on {out_valid, skid_valid}:
  - EMPTY (0,0): an input transfer loads M. Next state is ONE.
  - ONE (1,0):
    - input transfer with output transfer: load M; stay ONE.
    - input transfer without output transfer: load S; go FULL.
    - output transfer with no input: go EMPTY.
  - FULL (1,1): in_ready=0.
    - Output transfer: S moves to M, S is cleared, next state is ONE.
    - No input is accepted in FULL.
- in_ready is registered: next in_ready = ~next skid_valid. in_ready is 1 in EMPTY and ONE, 0 in FULL.
- Latency:
  - Instruction accepted at edge N appears on out_* after edge N (1 cycle) when not stalled.
  - Throughput is 1 instruction/cycle with out_ready held at 1.
- Ordering: strict FIFO. S is never presented before M.
- Flush:
  - At the edge, out_valid=0, skid_valid=0, in_ready=1.
  - An input transfer in the same cycle is discarded.
  - Flush overrides every other event, including a simultaneous output transfer. That output transfer still counts for downstream, since downstream sampled it.
  - Data registers may hold stale values after flush.
- Reset mid-operation: contents are dropped immediately (async). No output transfer occurs after reset asserts.
- No arithmetic: immediates are passed raw. Sign extension belongs downstream.
- Fields overlap by design (ra/rb/rc/imm/md). Downstream selects by out_fmt.

Test Plan:
- Reset then single instruction: in_inst=0x4A3C_0005, pc=0x100, out_ready=1.
  - Next cycle: out_valid=1, opcode=0x09, fmt=01, ra=0x08, rb=0x1E, imm18=0x00005, uses_imm=1.
- Stream of 4 instructions back-to-back with out_ready=1:
  - Outputs appear on consecutive cycles in order.
  - in_ready stays 1, no bubbles.
- Backpressure: hold out_ready=0 and offer 3 instructions.
  - First 2 are accepted; in_ready drops to 0 after the second.
  - Third is held by fetch; out_* stay on the first.
  - Release out_ready: order is 1, 2, 3, and in_ready returns to 1 one cycle after the first drain.
- md22 boundary: inst=0x8020_0000.
  - fmt=10, md22=0x200000 (MSB set), uses_md=1, uses_imm=0.
- Flush in FULL state with simultaneous in_valid=1:
  - Next cycle out_valid=0, in_ready=1.
  - The flushed and incoming instructions never appear.
- Async reset asserted mid-cycle while FULL: out_valid and in_ready change immediately (out_valid=0, in_ready=1) without waiting for a clock edge.

Source files
------------

// File: rtl/decode_field_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_field_stage
//  Description : Fetch-to-extender pipeline stage. Registers instructions over
//                a valid/ready handshake through a 2-entry skid buffer and
//                splits them into opcode/register/raw-immediate fields.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_field_stage #(
    parameter int INST_W = 32,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [4:0]        out_opcode,
    output logic [1:0]        out_fmt,
    output logic [4:0]        out_ra,
    output logic [4:0]        out_rb,
    output logic [4:0]        out_rc,
    output logic [17:0]       out_imm18,
    output logic [21:0]       out_md22,
    output logic              out_uses_imm,
    output logic              out_uses_md
);

    // State encoding is {out_valid, skid_valid} so both flags fall out directly.
    localparam logic [1:0] c_st_empty = 2'b00;
    localparam logic [1:0] c_st_one   = 2'b10;
    localparam logic [1:0] c_st_full  = 2'b11;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_in_ready;
    logic [INST_W-1:0] r_m_inst;
    logic [PC_W-1:0]   r_m_pc;
    logic [INST_W-1:0] r_s_inst;
    logic [PC_W-1:0]   r_s_pc;

    logic w_in_xfer;
    logic w_out_xfer;
    logic w_load_m;
    logic w_load_s;
    logic w_move_s;
    logic w_out_valid;

    assign w_out_valid = r_state[1];
    assign w_in_xfer   = in_valid & r_in_ready;
    assign w_out_xfer  = w_out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_empty;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= ~w_state_nxt[0];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_m    = 1'b0;
        w_load_s    = 1'b0;
        w_move_s    = 1'b0;
        if (flush) begin
            // Flush wins over any concurrent transfer; incoming data is dropped.
            w_state_nxt = c_st_empty;
        end else begin
            case (r_state)
                c_st_empty: begin
                    if (w_in_xfer) begin
                        w_load_m    = 1'b1;
                        w_state_nxt = c_st_one;
                    end
                end
                c_st_one: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_load_m = 1'b1;
                    end else if (w_in_xfer) begin
                        w_load_s    = 1'b1;
                        w_state_nxt = c_st_full;
                    end else if (w_out_xfer) begin
                        w_state_nxt = c_st_empty;
                    end
                end
                c_st_full: begin
                    if (w_out_xfer) begin
                        w_move_s    = 1'b1;
                        w_state_nxt = c_st_one;
                    end
                end
                default: w_state_nxt = c_st_empty;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_inst <= '0;
            r_m_pc   <= '0;
        end else if (w_load_m) begin
            r_m_inst <= in_inst;
            r_m_pc   <= in_pc;
        end else if (w_move_s) begin
            r_m_inst <= r_s_inst;
            r_m_pc   <= r_s_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_inst <= '0;
            r_s_pc   <= '0;
        end else if (w_load_s) begin
            r_s_inst <= in_inst;
            r_s_pc   <= in_pc;
        end else if (w_move_s) begin
            r_s_inst <= '0;
            r_s_pc   <= '0;
        end
    end

    // Fields overlap intentionally; downstream picks by out_fmt.
    assign in_ready     = r_in_ready;
    assign out_valid    = w_out_valid;
    assign out_pc       = r_m_pc;
    assign out_opcode   = r_m_inst[31:27];
    assign out_fmt      = r_m_inst[31:30];
    assign out_ra       = r_m_inst[26:22];
    assign out_rb       = r_m_inst[21:17];
    assign out_rc       = r_m_inst[16:12];
    assign out_imm18    = r_m_inst[17:0];
    assign out_md22     = r_m_inst[21:0];
    assign out_uses_imm = (r_m_inst[31:30] == 2'b01);
    assign out_uses_md  = r_m_inst[31];

endmodule
`default_nettype wire

// File: tb/tb_decode_field_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_field_stage
//  Description : Directed self-checking bench for decode_field_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_field_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_opcode;
    logic [1:0]  out_fmt;
    logic [4:0]  out_ra;
    logic [4:0]  out_rb;
    logic [4:0]  out_rc;
    logic [17:0] out_imm18;
    logic [21:0] out_md22;
    logic        out_uses_imm;
    logic        out_uses_md;

    int n_pass;
    int n_total;

    decode_field_stage #(.INST_W(32), .PC_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_inst      (in_inst),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_opcode   (out_opcode),
        .out_fmt      (out_fmt),
        .out_ra       (out_ra),
        .out_rb       (out_rb),
        .out_rc       (out_rc),
        .out_imm18    (out_imm18),
        .out_md22     (out_md22),
        .out_uses_imm (out_uses_imm),
        .out_uses_md  (out_uses_md)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_opcode", out_opcode, 0);
        step();

        // Single instruction, imm18 format
        offer(32'h4A3C_0005, 32'h100);
        step();
        in_valid = 1'b0;
        chk("single_valid", out_valid, 1);
        chk("single_pc", out_pc, 32'h100);
        chk("single_opcode", out_opcode, 5'h09);
        chk("single_fmt", out_fmt, 2'b01);
        chk("single_ra", out_ra, 5'h08);
        chk("single_rb", out_rb, 5'h1E);
        chk("single_imm18", out_imm18, 18'h00005);
        chk("single_uses_imm", out_uses_imm, 1);
        chk("single_uses_md", out_uses_md, 0);
        step();
        chk("single_drained", out_valid, 0);

        // Back-to-back stream of four
        for (int k = 0; k < 4; k++) begin
            offer({5'(k + 1), 27'h0}, 32'h200 + 32'(4 * k));
            step();
            chk("stream_valid", out_valid, 1);
            chk("stream_pc", out_pc, 32'h200 + 32'(4 * k));
            chk("stream_opcode", out_opcode, 5'(k + 1));
            chk("stream_in_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_drained", out_valid, 0);

        // Backpressure: A, B accepted, C held by fetch
        out_ready = 1'b0;
        offer(32'h0800_0000, 32'h300);
        step();
        chk("bp_a_pc", out_pc, 32'h300);
        chk("bp_in_ready_one", in_ready, 1);
        offer(32'h1000_0000, 32'h304);
        step();
        chk("bp_full_in_ready", in_ready, 0);
        chk("bp_hold_a_pc", out_pc, 32'h300);
        offer(32'h1800_0000, 32'h308);
        step();
        chk("bp_still_full", in_ready, 0);
        chk("bp_still_a_pc", out_pc, 32'h300);
        chk("bp_still_a_op", out_opcode, 5'h01);
        out_ready = 1'b1;
        step();
        chk("bp_b_pc", out_pc, 32'h304);
        chk("bp_in_ready_back", in_ready, 1);
        chk("bp_b_valid", out_valid, 1);
        step();
        in_valid = 1'b0;
        chk("bp_c_pc", out_pc, 32'h308);
        chk("bp_c_op", out_opcode, 5'h03);
        step();
        chk("bp_drained", out_valid, 0);

        // md22 boundary
        offer(32'h8020_0000, 32'h400);
        step();
        in_valid = 1'b0;
        chk("md_fmt", out_fmt, 2'b10);
        chk("md_opcode", out_opcode, 5'h10);
        chk("md_md22", out_md22, 22'h200000);
        chk("md_uses_md", out_uses_md, 1);
        chk("md_uses_imm", out_uses_imm, 0);
        step();

        // Flush in FULL with simultaneous input
        out_ready = 1'b0;
        offer(32'h2000_0000, 32'h500);
        step();
        offer(32'h2800_0000, 32'h504);
        step();
        chk("fl_full", in_ready, 0);
        flush = 1'b1;
        offer(32'h3000_0000, 32'h508);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 1);
        out_ready = 1'b1;
        step();
        chk("fl_stays_empty", out_valid, 0);
        offer(32'h3800_0000, 32'h600);
        step();
        in_valid = 1'b0;
        chk("fl_next_pc", out_pc, 32'h600);
        chk("fl_next_valid", out_valid, 1);
        step();

        // Async reset while FULL
        out_ready = 1'b0;
        offer(32'h4000_0000, 32'h700);
        step();
        offer(32'h4800_0000, 32'h704);
        step();
        in_valid = 1'b0;
        chk("ar_full", in_ready, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_in_ready", in_ready, 1);
        chk("ar_out_pc", out_pc, 0);
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        chk("ar_stays_empty", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
